// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, FSM state type and request legality check for the load/store unit.
// Comb-only helpers; no latency and no flow control live here.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } lsu_state_e;

    // Illegal encodings and misaligned halfword/word addresses both end as an error response.
    function automatic logic req_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic illegal;
        logic misaligned;
        if (we) begin
            illegal = f3[2] || (f3 == 3'b011);
        end else begin
            illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        misaligned = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
// Purely combinational: zero latency, no backpressure.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (i_off)
            2'd0:    byte_v = i_rdata[7:0];
            2'd1:    byte_v = i_rdata[15:8];
            2'd2:    byte_v = i_rdata[23:16];
            default: byte_v = i_rdata[31:24];
        endcase
        half_v = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_B:    o_load = {{24{byte_v[7]}}, byte_v};
            F3_BU:   o_load = {24'h0, byte_v};
            F3_H:    o_load = {{16{half_v[15]}}, half_v};
            F3_HU:   o_load = {16'h0, half_v};
            default: o_load = i_rdata;
        endcase
    end

    // Only the addressed lane is replaced; every other byte of the old word passes through.
    always_comb begin
        o_merge = i_rdata;
        case (i_funct3)
            F3_B: begin
                case (i_off)
                    2'd0:    o_merge[7:0]   = i_wdata[7:0];
                    2'd1:    o_merge[15:8]  = i_wdata[7:0];
                    2'd2:    o_merge[23:16] = i_wdata[7:0];
                    default: o_merge[31:24] = i_wdata[7:0];
                endcase
            end
            F3_H: begin
                if (i_off[1]) begin
                    o_merge[31:16] = i_wdata[15:0];
                end else begin
                    o_merge[15:0] = i_wdata[15:0];
                end
            end
            default: o_merge = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control: one request at a time, RMW for SB/SH since memory has no byte enables.
// Response 1 (err) / 2 (load, SW) / 3 (SB/SH) cycles after accept; ready only in IDLE, no rsp backpressure.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_wren,
    input  logic [31:0] i_mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] data_q, data_d;

    logic [31:0] load_v;
    logic [31:0] merge_v;

    lsu_align u_align (
        .i_rdata  (i_mem_rdata),
        .i_off    (addr_q[1:0]),
        .i_funct3 (f3_q),
        .i_wdata  (wdata_q),
        .o_load   (load_v),
        .o_merge  (merge_v)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    f3_d    = i_req_funct3;
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    data_d  = 32'h0;
                    err_d   = req_err(i_req_we, i_req_funct3, i_req_addr[1:0]);
                    state_d = err_d ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (we_q && (f3_q == F3_W)) begin
                    state_d = ST_DONE;
                end else if (we_q) begin
                    data_d  = merge_v;
                    state_d = ST_WRITE;
                end else begin
                    data_d  = load_v;
                    state_d = ST_DONE;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            default: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    logic access_sw;
    logic in_mem;
    assign access_sw = (state_q == ST_ACCESS) && we_q && (f3_q == F3_W);
    assign in_mem    = (state_q == ST_ACCESS) || (state_q == ST_WRITE);

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_mem_addr  = in_mem ? {addr_q[31:2], 2'b00} : 32'h0;
    assign o_mem_wdata = access_sw ? wdata_q : ((state_q == ST_WRITE) ? data_q : 32'h0);
    // Gated by i_reset so a pending RMW write cannot land in the reset cycle.
    assign o_mem_wren  = !i_reset && (access_sw || (state_q == ST_WRITE));
    assign o_rsp_valid = (state_q == ST_DONE);
    assign o_rsp_err   = (state_q == ST_DONE) && err_q;
    assign o_rsp_rdata = ((state_q == ST_DONE) && !err_q && !we_q) ? data_q : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a word memory model and response/write scoreboards.
module tb_lsu_ctrl;

    logic        i_clk;
    logic        i_reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_mem_wren;
    logic [31:0] i_mem_rdata;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    logic [31:0] mem [16];
    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    lsu_ctrl dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_err    (o_rsp_err),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wren   (o_mem_wren),
        .i_mem_rdata  (i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    assign i_mem_rdata = mem[o_mem_addr[5:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Monitor: samples on the falling edge and applies memory writes there.
    always @(negedge i_clk) begin
        rsp_t r;
        wr_t  w;
        cyc++;
        if (o_rsp_valid) begin
            chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
            if (rsp_q.size() != 0) begin
                r = rsp_q.pop_front();
                chk("rsp_cycle", cyc, r.cyc);
                chk("rsp_rdata", o_rsp_rdata, r.rdata);
                chk("rsp_err", 32'(o_rsp_err), 32'(r.err));
            end
        end
        if (o_mem_wren) begin
            chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                w = wr_q.pop_front();
                chk("wr_cycle", cyc, w.cyc);
                chk("wr_addr", o_mem_addr, w.addr);
                chk("wr_data", o_mem_wdata, w.data);
            end
            mem[o_mem_addr[5:2]] = o_mem_wdata;
        end
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!o_req_ready && n < 10) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk(tag, 32'(o_req_ready), 32'd1);
    endtask

    // Called at posedge+#1 with the DUT idle; holds junk on i_req_* for a cycle while busy.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int rsp_lat, input logic [31:0] exp_rdata,
                          input logic exp_err, input int wr_lat, input logic [31:0] wr_data);
        rsp_t r;
        wr_t  w;
        r.cyc = cyc + 1 + rsp_lat;
        r.rdata = exp_rdata;
        r.err = exp_err;
        rsp_q.push_back(r);
        if (wr_lat > 0) begin
            w.cyc  = cyc + 1 + wr_lat;
            w.addr = {addr[31:2], 2'b00};
            w.data = wr_data;
            wr_q.push_back(w);
        end
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wdata;
        @(posedge i_clk);
        #1;
        chk("ready_busy", 32'(o_req_ready), 32'd0);
        i_req_we     = 1'b1;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h20;
        i_req_wdata  = 32'h0BAD0BAD;
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        wait_ready("ready_return");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        i_reset      = 1'b1;
        i_req_valid  = 1'b0;
        i_req_we     = 1'b0;
        i_req_funct3 = 3'h0;
        i_req_addr   = 32'h0;
        i_req_wdata  = 32'h0;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        chk("rst_ready", 32'(o_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(o_rsp_err), 32'd0);
        chk("rst_mem_wren", 32'(o_mem_wren), 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        chk("rst_mem_wdata", o_mem_wdata, 32'd0);

        // SW: write at cycle 1, response at cycle 2
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 32'hDEADBEEF);
        chk("sw_mem", mem[4], 32'hDEADBEEF);

        // SB into upper lane
        mem[4] = 32'h11223344;
        do_req(1'b1, 3'b000, 32'h13, 32'h000000AB, 3, 32'h0, 1'b0, 2, 32'hAB223344);
        chk("sb_mem", mem[4], 32'hAB223344);

        // SB into lane 1, upper data bits must be ignored
        mem[4] = 32'h11223344;
        do_req(1'b1, 3'b000, 32'h11, 32'hFFFFFF5A, 3, 32'h0, 1'b0, 2, 32'h11225A44);

        // SH into upper half
        mem[4] = 32'h11223344;
        do_req(1'b1, 3'b001, 32'h12, 32'h00005566, 3, 32'h0, 1'b0, 2, 32'h55663344);
        chk("sh_mem", mem[4], 32'h55663344);

        // Loads on 0x8000F0FF
        mem[0] = 32'h8000F0FF;
        do_req(1'b0, 3'b000, 32'h0, 32'h0, 2, 32'hFFFFFFFF, 1'b0, 0, 32'h0);
        do_req(1'b0, 3'b100, 32'h1, 32'h0, 2, 32'h000000F0, 1'b0, 0, 32'h0);
        do_req(1'b0, 3'b001, 32'h2, 32'h0, 2, 32'hFFFF8000, 1'b0, 0, 32'h0);
        do_req(1'b0, 3'b101, 32'h2, 32'h0, 2, 32'h00008000, 1'b0, 0, 32'h0);
        do_req(1'b0, 3'b010, 32'h0, 32'h0, 2, 32'h8000F0FF, 1'b0, 0, 32'h0);
        do_req(1'b0, 3'b000, 32'h3, 32'h0, 2, 32'hFFFFFF80, 1'b0, 0, 32'h0);

        // Errors: misaligned LW, misaligned SH, illegal load funct3, illegal store funct3
        mem[1] = 32'hCAFEF00D;
        do_req(1'b0, 3'b010, 32'h6, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
        do_req(1'b1, 3'b001, 32'h3, 32'h12345678, 1, 32'h0, 1'b1, 0, 32'h0);
        do_req(1'b0, 3'b011, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
        do_req(1'b1, 3'b100, 32'h4, 32'h77777777, 1, 32'h0, 1'b1, 0, 32'h0);
        chk("err_mem0", mem[0], 32'h8000F0FF);
        chk("err_mem1", mem[1], 32'hCAFEF00D);
        chk("err_mem4", mem[4], 32'h55663344);

        // Reset during the ACCESS cycle of an SB: no write, no response
        mem[4] = 32'h11223344;
        i_req_valid  = 1'b1;
        i_req_we     = 1'b1;
        i_req_funct3 = 3'b000;
        i_req_addr   = 32'h11;
        i_req_wdata  = 32'h000000CD;
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        i_reset     = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        chk("rst_mid_ready", 32'(o_req_ready), 32'd1);
        chk("rst_mid_rsp", 32'(o_rsp_valid), 32'd0);
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_mid_mem", mem[4], 32'h11223344);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h11223344, 1'b0, 0, 32'h0);

        repeat (2) @(posedge i_clk);
        #1;
        chk("rsp_q_drained", rsp_q.size(), 32'd0);
        chk("wr_q_drained", wr_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control stage between the execute stage and the word-wide data memory. Accepts one RV32I load or store request at a time and turns it into word-aligned memory accesses. The data memory has no byte enables, so byte and halfword stores use a read-modify-write sequence. Loads are returned sign- or zero-extended, and misaligned or illegal requests are flagged without touching memory.

## Interface
- No parameters; data and address widths are fixed at 32.
- i_clk  in  1  clock.
- i_reset  in  1  reset; synchronous, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  block can accept a request; high only in IDLE.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data; the low byte/half is used for SB/SH.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors.
- o_rsp_err  out  1  misaligned or illegal request; valid with o_rsp_valid.
- o_mem_addr  out  32  word address to memory, bits [1:0] always 00.
- o_mem_wdata  out  32  word write data.
- o_mem_wren  out  1  memory write enable.
- i_mem_rdata  in  32  combinational read data for o_mem_addr.

## Operation
- States: IDLE, ACCESS, WRITE, DONE.
- **IDLE**
  - o_req_ready=1.
  - On i_req_valid, latch we/funct3/addr/wdata.
  - Illegal or misaligned request: set err and go to DONE.
  - Otherwise go to ACCESS.
- **Illegal funct3**
  - Loads: 011, 110, 111.
  - Stores: any value with funct3[2]=1, or 011.
- **Misaligned**
  - Halfword: addr[0]=1.
  - Word: addr[1:0]≠00.
- **ACCESS**: o_mem_addr={addr[31:2],2'b00}.
  - SW: o_mem_wren=1, o_mem_wdata=wdata, go to DONE.
  - SB/SH: o_mem_wren=0; capture i_mem_rdata, merge the store lane(s) selected by addr[1:0], go to WRITE.
  - Loads: capture i_mem_rdata, extract the lane selected by addr[1:0], extend (LB/LH sign, LBU/LHU zero), go to DONE.
- **WRITE**: same o_mem_addr, o_mem_wren=1, o_mem_wdata=merged word, go to DONE.
- **DONE**: o_rsp_valid=1 with rdata/err, then go to IDLE.
- **Lane rules**
  - Byte lane n occupies bits [8n+7:8n].
  - Halfword at addr[1]=1 occupies [31:16].
  - Unselected bytes of a merged store are preserved exactly.
- Error requests never assert o_mem_wren and return o_rsp_rdata=0.
- o_mem_wren=0 in IDLE and DONE. o_mem_wren is forced to 0 whenever i_reset=1.

## Timing
- Request accepted at cycle 0 (valid & ready).
- o_rsp_valid response cycle:
  - Loads and SW: cycle 2.
  - SB/SH: cycle 3.
  - Error requests: cycle 1.
- Memory write cycle:
  - SW: cycle 1.
  - SB/SH: cycle 2.
- Throughput: one request per 2 (error), 3 (load/SW) or 4 (SB/SH) cycles. No back-to-back accept from DONE.
- No response backpressure; the consumer must sample o_rsp_valid.
- Reset values: state IDLE; o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_mem_wren=0, o_mem_addr=0, o_mem_wdata=0. o_req_ready=1 from the first cycle after reset.
- Reset mid-operation: the request is dropped with no response. A pending SB/SH write is aborted, and no write occurs in the reset cycle or after it.
- i_req_* inputs are ignored when o_req_ready=0.

## Structure
- lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum lsu_state_e.
- Sub-module lsu_align, purely combinational:
  - Load lane extract and extend: (rdata, addr[1:0], funct3) → load value.
  - Store merge: (old word, wdata, addr[1:0], funct3) → merged word.
- lsu_ctrl holds the FSM and request/capture registers.

## Test plan
- **SW**: addr 0x10, data 0xDEADBEEF → o_mem_wren=1 at cycle 1, o_mem_addr 0x10; rsp at cycle 2 with err=0.
- **SB**: memory word 0x11223344, SB addr 0x13, data 0xAB → read at cycle 1, write 0xAB223344 at cycle 2, rsp at cycle 3.
- **SH**: SH addr 0x12, data 0x5566 on word 0x11223344 → 0x55663344.
- **Loads** on word 0x8000F0FF:
  - LB addr 0x0 → 0xFFFFFFFF.
  - LBU addr 0x1 → 0x000000F0.
  - LH addr 0x2 → 0xFFFF8000.
  - LHU addr 0x2 → 0x00008000.
  - LW → 0x8000F0FF.
- **Errors**:
  - LW addr 0x6, SH addr 0x3, funct3 011 load → err=1, rdata 0 at cycle 1, no o_mem_wren.
  - Memory unchanged after all three.
- **Reset**: SB accepted, i_reset asserted in the ACCESS cycle → no write ever issued, no rsp. o_req_ready=1 on the cycle after reset deasserts, and a following LW completes normally.
